// File: rtl/tx_control_if.sv
// Host/UART-side signal bundle for tx_control.
// Latency: none (wires only).
// Backpressure: tx_busy from the UART core stalls the byte sequencer.
//
// Signals:
//   trigger, tx_result   - request pulse and the result it carries
//   clr_overrun          - clears the sticky overrun flag
//   tx_busy              - UART TX core is shifting a byte
//   tx_start, tx_data    - byte launch pulse and byte to the UART TX core
//   busy, done, overrun  - sequencer status
//   state_leds           - one-hot sequencer state
// Modports: master = requester/UART side, slave = tx_control.
interface tx_control_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  trigger;
   logic [DATA_WIDTH-1:0] tx_result;
   logic                  clr_overrun;
   logic                  tx_busy;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic                  busy;
   logic                  done;
   logic                  overrun;
   logic [5:0]            state_leds;

   modport master (
      output trigger, tx_result, clr_overrun, tx_busy,
      input  tx_start, tx_data, busy, done, overrun, state_leds
   );

   modport slave (
      input  trigger, tx_result, clr_overrun, tx_busy,
      output tx_start, tx_data, busy, done, overrun, state_leds
   );
endinterface

// File: rtl/tx_control.sv
// Sends a DATA_WIDTH-bit result to the UART TX core one byte at a time.
// Latency: trigger accepted in cycle n -> tx_start in n+1; NUM_BYTES*(B+2)+(NUM_BYTES-1)*GAP_CYCLES+1 to done.
// Backpressure: waits on tx_busy per byte; one request buffered while busy, further ones dropped (overrun).
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   bus (slave) - trigger/tx_result/clr_overrun/tx_busy in;
//                 tx_start/tx_data/busy/done/overrun/state_leds out
// Parameters: DATA_WIDTH (multiple of 8, must match bus), LSB_FIRST, GAP_CYCLES.
module tx_control #(
   parameter int DATA_WIDTH = 16,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   tx_control_if.slave bus
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   // One-hot encoding so the state vector doubles as the LED output.
   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_START     = 6'b000010,
      S_WAIT_ACK  = 6'b000100,
      S_WAIT_DONE = 6'b001000,
      S_GAP       = 6'b010000,
      S_DONE      = 6'b100000
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] pend_q, pend_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic                  overrun_q, overrun_d;

   logic                  trig_busy;
   logic                  drop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         byte_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         byte_cnt_q   <= byte_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      byte_cnt_d   = byte_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      overrun_d    = overrun_q;

      // Any trigger outside IDLE goes to the one-deep pending slot; if the
      // slot is already full the request is lost. Setting beats clearing.
      trig_busy = bus.trigger && (state_q != S_IDLE);
      drop      = trig_busy && pend_valid_q;

      if (trig_busy && !pend_valid_q) begin
         pend_d       = bus.tx_result;
         pend_valid_d = 1'b1;
      end

      if (drop) begin
         overrun_d = 1'b1;
      end else if (bus.clr_overrun) begin
         overrun_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.trigger) begin
               shift_d    = bus.tx_result;
               byte_cnt_d = CNT_W'(NUM_BYTES - 1);
               state_d    = S_START;
            end
         end
         S_START: begin
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (byte_cnt_q != '0) begin
                  byte_cnt_d = byte_cnt_q - CNT_W'(1);
                  shift_d    = LSB_FIRST ? (shift_q >> 8) : (shift_q << 8);
                  if (GAP_CYCLES == 0) begin
                     state_d = S_START;
                  end else begin
                     gap_cnt_d = '0;
                     state_d   = S_GAP;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = S_START;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         S_DONE: begin
            // A request captured in this same cycle is left pending; only
            // one that was already waiting is launched here.
            if (pend_valid_q) begin
               shift_d      = pend_q;
               pend_valid_d = 1'b0;
               byte_cnt_d   = CNT_W'(NUM_BYTES - 1);
               state_d      = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      bus.tx_start   = (state_q == S_START);
      bus.tx_data    = LSB_FIRST ? shift_q[7:0] : shift_q[DATA_WIDTH-1 -: 8];
      bus.busy       = (state_q != S_IDLE);
      bus.done       = (state_q == S_DONE);
      bus.overrun    = overrun_q;
      bus.state_leds = state_q;
   end

endmodule

// File: tb/tb_tx_control.sv
// Bench for tx_control: two instances (LSB-first/no gap, MSB-first/3-cycle gap)
// Latency: n/a. Backpressure: a UART model per instance drives tx_busy.
module tb_tx_control;
   localparam int DW = 16;
   localparam int NB = DW / 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tx_control_if #(.DATA_WIDTH(DW)) bus0 ();
   tx_control_if #(.DATA_WIDTH(DW)) bus1 ();

   tx_control #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   tx_control #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0), .GAP_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   int nerr = 0;
   int nchk = 0;
   int cyc  = 0;

   // UART model
   int uart_b     = 10;
   bit uart_stall = 1'b0;
   int ucnt[2];
   bit prev_start[2];

   // Reference model: transaction-level timing from the latency rules
   bit             chk_en = 1'b1;
   bit             m_act[2];
   int             m_done[2];
   bit             m_pv[2];
   logic [DW-1:0]  m_pd[2];
   bit             m_ovr[2];
   typedef struct {int k; int cyc; logic [7:0] b;} exp_t;
   exp_t xq[$];

   // Observation log
   int         n_start[2];
   int         n_done[2];
   int         last_done[2];
   int         gap_seen[2];
   logic [7:0] logb[2][64];
   int         logc[2][64];

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nchk++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic clear_obs();
      for (int k = 0; k < 2; k++) begin
         n_start[k] = 0; n_done[k] = 0; gap_seen[k] = 0; last_done[k] = -1;
      end
   endtask

   task automatic launch(input int k, input int c, input logic [DW-1:0] d);
      int   per;
      exp_t e;
      per       = uart_b + 2 + gap_of(k);
      m_act[k]  = 1'b1;
      m_done[k] = c + NB * (uart_b + 2) + (NB - 1) * gap_of(k) + 1;
      for (int i = 0; i < NB; i++) begin
         e.k   = k;
         e.cyc = c + 1 + i * per;
         e.b   = (k == 0) ? d[8*i +: 8] : d[8*(NB-1-i) +: 8];
         xq.push_back(e);
      end
   endtask

   task automatic model_step(input int k, input bit trig, input logic [DW-1:0] res,
                             input bit clr, input bit rst);
      bit            pv_old;
      logic [DW-1:0] pd_old;
      if (rst) begin
         m_act[k] = 1'b0; m_pv[k] = 1'b0; m_pd[k] = '0; m_ovr[k] = 1'b0;
         for (int i = xq.size() - 1; i >= 0; i--) if (xq[i].k == k) xq.delete(i);
         return;
      end
      pv_old = m_pv[k];
      pd_old = m_pd[k];
      if (m_act[k] && trig && pv_old) m_ovr[k] = 1'b1;
      else if (clr)                   m_ovr[k] = 1'b0;
      if (!m_act[k]) begin
         if (trig) launch(k, cyc, res);
      end else begin
         if (trig && !pv_old) begin
            m_pv[k] = 1'b1; m_pd[k] = res;
         end
         if (cyc == m_done[k]) begin
            if (pv_old) begin
               m_pv[k] = 1'b0;
               launch(k, cyc, pd_old);
            end else begin
               m_act[k] = 1'b0;
            end
         end
      end
   endtask

   // One clock: UART update, observe/check outputs, apply inputs, advance model.
   task automatic cycle(input bit trig, input logic [DW-1:0] res, input bit clr, input bit rst);
      logic       o_start[2], o_busy[2], o_done[2], o_ovr[2];
      logic [7:0] o_data[2];
      logic [5:0] o_leds[2];
      bit         exp_s;
      logic [7:0] exp_b;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (prev_start[k] && !uart_stall) ucnt[k] = uart_b;
         else if (ucnt[k] > 0)             ucnt[k] = ucnt[k] - 1;
      end
      bus0.tx_busy = (ucnt[0] > 0);
      bus1.tx_busy = (ucnt[1] > 0);

      o_start[0] = bus0.tx_start; o_start[1] = bus1.tx_start;
      o_busy[0]  = bus0.busy;     o_busy[1]  = bus1.busy;
      o_done[0]  = bus0.done;     o_done[1]  = bus1.done;
      o_ovr[0]   = bus0.overrun;  o_ovr[1]   = bus1.overrun;
      o_data[0]  = bus0.tx_data;  o_data[1]  = bus1.tx_data;
      o_leds[0]  = bus0.state_leds; o_leds[1] = bus1.state_leds;

      for (int k = 0; k < 2; k++) begin
         prev_start[k] = o_start[k];
         if (o_start[k] === 1'b1) begin
            logb[k][n_start[k] % 64] = o_data[k];
            logc[k][n_start[k] % 64] = cyc;
            n_start[k]++;
         end
         if (o_done[k] === 1'b1) begin
            n_done[k]++;
            last_done[k] = cyc;
         end
         if (o_leds[k][4] === 1'b1) gap_seen[k]++;
         if (chk_en) begin
            exp_s = 1'b0;
            exp_b = 8'h00;
            foreach (xq[i]) if (xq[i].k == k && xq[i].cyc == cyc) begin
               exp_s = 1'b1; exp_b = xq[i].b;
            end
            chk($sformatf("busy%0d", k), o_busy[k], m_act[k]);
            chk($sformatf("done%0d", k), o_done[k], m_act[k] && (m_done[k] == cyc));
            chk($sformatf("overrun%0d", k), o_ovr[k], m_ovr[k]);
            chk($sformatf("tx_start%0d", k), o_start[k], exp_s);
            chk($sformatf("leds_idle%0d", k), o_leds[k][0], !m_act[k]);
            chk($sformatf("leds_onehot%0d", k), $onehot(o_leds[k]), 1);
            if (exp_s) chk($sformatf("tx_data%0d", k), o_data[k], exp_b);
         end
      end
      for (int i = xq.size() - 1; i >= 0; i--) if (xq[i].cyc <= cyc) xq.delete(i);

      bus0.trigger = trig;  bus1.trigger = trig;
      bus0.tx_result = res; bus1.tx_result = res;
      bus0.clr_overrun = clr; bus1.clr_overrun = clr;
      reset = rst;
      for (int k = 0; k < 2; k++) model_step(k, trig, res, clr, rst);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int t;
      reset = 1'b1;
      bus0.trigger = 1'b0; bus1.trigger = 1'b0;
      bus0.tx_result = '0; bus1.tx_result = '0;
      bus0.clr_overrun = 1'b0; bus1.clr_overrun = 1'b0;
      bus0.tx_busy = 1'b0; bus1.tx_busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ucnt[k] = 0; prev_start[k] = 1'b0;
         m_act[k] = 1'b0; m_done[k] = 0; m_pv[k] = 1'b0; m_pd[k] = '0; m_ovr[k] = 1'b0;
      end
      clear_obs();

      // Reset state
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      idle(1);
      chk("rst_leds0", bus0.state_leds, 6'b000001);
      chk("rst_leds1", bus1.state_leds, 6'b000001);
      chk("rst_txdata0", bus0.tx_data, 8'h00);
      chk("rst_busy0", bus0.busy, 1'b0);
      chk("rst_overrun1", bus1.overrun, 1'b0);

      // Plan 1: A53C, B = 10
      clear_obs();
      t = cyc;
      cycle(1'b1, 16'hA53C, 1'b0, 1'b0);
      idle(40);
      chk("p1_nstart0", n_start[0], 2);
      chk("p1_byte0_0", logb[0][0], 8'h3C);
      chk("p1_byte0_1", logb[0][1], 8'hA5);
      chk("p1_ndone0", n_done[0], 1);
      chk("p1_latency0", last_done[0] - t, 25);
      chk("p1_byte1_0", logb[1][0], 8'hA5);
      chk("p1_byte1_1", logb[1][1], 8'h3C);
      chk("p1_latency1", last_done[1] - t, 28);
      chk("p1_busy_after0", bus0.busy, 1'b0);

      // Plan 2: 1234, MSB-first with a 3-cycle gap on dut1
      clear_obs();
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      idle(40);
      chk("p2_byte1_0", logb[1][0], 8'h12);
      chk("p2_byte1_1", logb[1][1], 8'h34);
      chk("p2_gap1", gap_seen[1], 3);
      chk("p2_spacing1", logc[1][1] - logc[1][0], 10 + 2 + 3);
      chk("p2_gap0", gap_seen[0], 0);
      chk("p2_byte0_0", logb[0][0], 8'h34);

      // Plan 3: second request queued during WAIT_DONE
      clear_obs();
      t = cyc;
      cycle(1'b1, 16'h0001, 1'b0, 1'b0);
      idle(4);
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
      idle(70);
      chk("p3_nstart0", n_start[0], 4);
      chk("p3_b0", logb[0][0], 8'h01);
      chk("p3_b1", logb[0][1], 8'h00);
      chk("p3_b2", logb[0][2], 8'hEF);
      chk("p3_b3", logb[0][3], 8'hBE);
      chk("p3_restart0", logc[0][2], t + 26);
      chk("p3_ndone0", n_done[0], 2);
      chk("p3_overrun0", bus0.overrun, 1'b0);

      // Plan 4: overrun, clear, and clear coincident with a drop
      clear_obs();
      cycle(1'b1, 16'h1A2B, 1'b0, 1'b0);
      idle(4);
      cycle(1'b1, 16'h3C4D, 1'b0, 1'b0);
      cycle(1'b1, 16'h5E6F, 1'b0, 1'b0);
      cycle(1'b1, 16'h7081, 1'b0, 1'b0);
      idle(70);
      chk("p4_nstart0", n_start[0], 4);
      chk("p4_b2", logb[0][2], 8'h4D);
      chk("p4_b3", logb[0][3], 8'h3C);
      chk("p4_overrun_set0", bus0.overrun, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(1);
      chk("p4_overrun_clr0", bus0.overrun, 1'b0);
      cycle(1'b1, 16'h1111, 1'b0, 1'b0);
      idle(3);
      cycle(1'b1, 16'h2222, 1'b0, 1'b0);
      cycle(1'b1, 16'h3333, 1'b1, 1'b0);
      idle(1);
      chk("p4_set_wins0", bus0.overrun, 1'b1);
      chk("p4_set_wins1", bus1.overrun, 1'b1);
      idle(70);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(1);

      // Plan 5: reset in WAIT_DONE of the first byte with a pending request
      clear_obs();
      cycle(1'b1, 16'hC0DE, 1'b0, 1'b0);
      idle(1);
      cycle(1'b1, 16'hF00D, 1'b0, 1'b0);
      idle(1);
      chk("p5_in_wait_done0", bus0.state_leds, 6'b001000);
      cycle(1'b0, '0, 1'b0, 1'b1);
      idle(1);
      chk("p5_leds0", bus0.state_leds, 6'b000001);
      chk("p5_busy0", bus0.busy, 1'b0);
      chk("p5_leds1", bus1.state_leds, 6'b000001);
      idle(40);
      chk("p5_nostart0", n_start[0], 1);
      cycle(1'b1, 16'h1357, 1'b0, 1'b0);
      idle(80);
      chk("p5_nstart0", n_start[0], 3);
      chk("p5_b1", logb[0][1], 8'h57);
      chk("p5_b2", logb[0][2], 8'h13);
      chk("p5_ndone0", n_done[0], 1);

      // Randomized traffic against the model
      for (int seg = 0; seg < 6; seg++) begin
         uart_b = $urandom_range(1, 8);
         for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 31) == 0, 1'b0);
         end
         idle(120);
      end

      // Plan 6: tx_busy stuck low holds WAIT_ACK
      uart_b = 10;
      idle(130);
      chk_en = 1'b0;
      clear_obs();
      uart_stall = 1'b1;
      cycle(1'b1, 16'h2468, 1'b0, 1'b0);
      idle(30);
      chk("p6_leds0", bus0.state_leds, 6'b000100);
      chk("p6_leds1", bus1.state_leds, 6'b000100);
      chk("p6_nstart0", n_start[0], 1);
      chk("p6_nstart1", n_start[1], 1);
      uart_stall = 1'b0;
      ucnt[0] = 3;
      ucnt[1] = 3;
      for (int i = 0; i < 100; i++) begin
         if (n_done[0] >= 1 && n_done[1] >= 1) break;
         idle(1);
      end
      chk("p6_ndone0", n_done[0], 1);
      chk("p6_ndone1", n_done[1], 1);
      chk("p6_nstart0_after", n_start[0], 2);
      chk("p6_b0_0", logb[0][0], 8'h68);
      chk("p6_b0_1", logb[0][1], 8'h24);
      chk("p6_b1_0", logb[1][0], 8'h24);
      idle(2);
      chk("p6_idle0", bus0.state_leds, 6'b000001);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
